// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// FSM encodings and default widths, also used by multiplier-check benches.
package seq_restoring_divider_pkg;

    localparam int DEF_N = 6;
    localparam int DEF_D = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_full_subtractor.sv
// One-bit full subtractor cell in gate-primitive form.
// Computes a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    wire axb;
    wire na;
    wire naxb;
    wire t1;
    wire t2;

    xor g_axb  (axb, a, b);
    xor g_diff (diff, axb, bin);
    not g_na   (na, a);
    and g_t1   (t1, na, b);
    not g_naxb (naxb, axb);
    and g_t2   (t2, naxb, bin);
    or  g_bout (bout, t1, t2);

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock.
// Start/done handshake; divide-by-zero short-circuits to DONE.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int D = DEF_D,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         dbz
);

    div_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  q_q;
    logic [D-1:0]  v_q;
    logic [D:0]    r_q;
    logic [N-1:0]  quotient_q;
    logic [D-1:0]  remainder_q;
    logic          dbz_q;
    logic          done_q;
    logic          ready_q;

    logic [D:0]    r_shift;
    logic [D:0]    sub_b;
    logic [D:0]    diff;
    logic [D+1:0]  bc;
    logic          borrow;
    logic [D:0]    r_d;
    logic [N-1:0]  q_d;
    logic          r_msb_unused;

    // R[D] is always zero between iterations, so only the low bits shift up
    assign r_msb_unused = r_q[D];
    assign r_shift      = {r_q[D-1:0], q_q[N-1]};
    assign sub_b        = {1'b0, v_q};
    assign bc[0]        = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= D; i++) begin : g_sub
            full_subtractor u_fs (
                .a    (r_shift[i]),
                .b    (sub_b[i]),
                .bin  (bc[i]),
                .diff (diff[i]),
                .bout (bc[i+1])
            );
        end
    endgenerate

    // Restore on borrow; quotient bit is the inverted borrow
    assign borrow = bc[D+1];
    assign r_d    = borrow ? r_shift : diff;
    assign q_d    = {q_q[N-2:0], ~borrow};

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            v_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ready_q <= 1'b0;
                        if (divisor != '0) begin
                            q_q     <= dividend;
                            v_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            state_q <= BUSY;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d[D-1:0];
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Directed, random and exhaustive operands against an arithmetic model.
module tb_seq_restoring_divider;

    localparam int N = 6;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         dbz;

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0] prev_q;
    logic [D-1:0] prev_r;

    seq_restoring_divider #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division; hold keeps start high, scramble changes operands,
    // full adds handshake/stability checks.
    task automatic run_div(input logic [N-1:0] a, input logic [D-1:0] b,
                           input bit hold, input bit scramble,
                           input bit full);
        int   cyc;
        bit   seen;
        int   eq;
        int   er;
        int   edbz;
        int   elat;
        if (b == 0) begin
            eq   = (1 << N) - 1;
            er   = 0;
            edbz = 1;
            elat = 1;
        end else begin
            eq   = int'(a) / int'(b);
            er   = int'(a) % int'(b);
            edbz = 0;
            elat = N + 1;
        end
        cyc = 0;
        while (!ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_start", 32'(ready), 1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (scramble) begin
                dividend = N'($urandom);
                divisor  = D'($urandom);
            end
            if (done) begin
                seen = 1;
            end else if (full) begin
                check("busy_quotient_held", 32'(quotient), 32'(prev_q));
                check("busy_remainder_held", 32'(remainder), 32'(prev_r));
                check("busy_not_ready", 32'(ready), 0);
            end
        end
        check("done_seen", 32'(seen), 1);
        check("latency", 32'(cyc), 32'(elat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("dbz", 32'(dbz), 32'(edbz));
        if (full) check("done_not_ready", 32'(ready), 0);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 0);
        if (full) begin
            check("ready_after_done", 32'(ready), 1);
            check("quotient_kept", 32'(quotient), 32'(eq));
        end
        prev_q = N'(eq);
        prev_r = D'(er);
    endtask

    initial begin
        bit saw_done;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 3'd6;
        prev_q   = '0;
        prev_r   = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(dbz), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 1);
        check("post_rst_done", 32'(done), 0);

        run_div(6'd45, 3'd6, 0, 0, 1);
        run_div(6'd63, 3'd1, 0, 0, 1);
        run_div(6'd5,  3'd7, 0, 0, 1);
        run_div(6'd0,  3'd3, 0, 0, 1);
        run_div(6'd42, 3'd7, 0, 0, 1);
        run_div(6'd20, 3'd0, 0, 0, 1);
        run_div(6'd9,  3'd2, 0, 0, 1);
        run_div(6'd50, 3'd3, 1, 0, 1);
        run_div(6'd61, 3'd5, 0, 1, 1);
        run_div(6'd33, 3'd0, 1, 1, 1);

        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 3'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_dbz", 32'(dbz), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_ready", 32'(ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("midrst_no_done", 32'(saw_done), 0);
        prev_q = '0;
        prev_r = '0;
        run_div(6'd12, 3'd5, 0, 0, 1);

        repeat (40) begin
            run_div(N'($urandom), D'($urandom), 1'($urandom),
                    1'($urandom), 1);
        end

        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << D); b++) begin
                run_div(N'(a), D'(b), 0, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
